led_pattern_engine: RTL and testbench
=====================================

# led_pattern_engine

Parametrised LED pattern generator producing one of four animations on a WIDTH-bit LED bus, advanced by an internal selectable-rate step tick. It replaces the divided-clock, four-instance arrangement with a single clock domain: one prescaler generates a one-cycle step enable, and one shared pattern state machine is restarted cleanly on every mode or rate change. It sits directly between the board switches and the LED pins.

## Interface
- WIDTH, 8 — number of LEDs, minimum 4
- DIV0, 12_500_000 — clk cycles per step, freq_sel=0 (4 Hz at 50 MHz)
- DIV1, 6_250_000 — clk cycles per step, freq_sel=1
- DIV2, 3_125_000 — clk cycles per step, freq_sel=2
- DIV3, 1_562_500 — clk cycles per step, freq_sel=3
- CNT_W, 24 — prescaler width; must hold the largest DIVn-1
- clk  in  1  system clock; all flops rise-edge
- reset  in  1  one clock; reset is asynchronous and active-low
- freq_sel  in  2  step-rate select
- mode_sel  in  2  animation select
- pause  in  1  high freezes the animation and prescaler
- step  out  1  one-cycle pulse when the pattern advances
- OUT  out  WIDTH  LED drive, registered

## Operation
- Prescaler cnt: counts 0..DIVn-1 for the current freq_sel; when cnt==DIVn-1, step pulses for one cycle and cnt returns to 0. While pause=1, cnt holds and step=0.
- Mode 0, blink: state b, initial 0. OUT = all b. Each step toggles b.
- Mode 1, fill/empty: level k in 0..WIDTH, direction up, initial k=0. OUT = low k bits set. Up: k+1, turning down at WIDTH. Down: k-1, turning up at 0. Period is 2*WIDTH steps.
- Mode 2, runner: position p, initial 0. OUT = one-hot bit p. Each step sets p=(p+1) mod WIDTH. Wrap is WIDTH-1 → 0.
- Mode 3, stack: stack count f and dot d, initial f=0, d=0. OUT = top f bits set OR bit d (dot omitted when f==WIDTH). Each step:
  - if f==WIDTH, set f=0, d=0;
  - else if d==WIDTH-1-f, set f=f+1, d=0;
  - else d=d+1.
  - For WIDTH=8 the cycle is 37 steps; all-lit appears for 2 consecutive steps (f=7, then f=8).
- Restart: a change of mode_sel or freq_sel versus the value registered last cycle restores the selected mode's initial state, clears cnt and suppresses step that cycle. Restart takes priority over a coincident step.
- pause does not block restart.

## Timing
- Reset asserted gives OUT=0, step=0, cnt=0, all pattern state at its initial values, and mode/freq shadows = 0.
- OUT is registered from the pattern state: it changes 1 clk after the state, so 1 clk after step.
- After reset deasserts, OUT shows the mode's initial pattern on the first clk edge.
- The first step fires DIVn clk cycles after reset release or after a restart.
- Reset mid-animation aborts immediately; no partial frame is held.
- mode_sel and freq_sel are synchronous inputs; board switch synchronisation is done upstream.

## Configuration
- LED_BOUNCE_EN defined: mode 2 bounces instead of wrapping. p runs 0→WIDTH-1→0 with endpoints shown once, giving a period of 2*WIDTH-2 steps. Initial state is p=0, direction up.
- LED_BOUNCE_EN undefined: mode 2 wraps as above and the direction flop is absent.
- All other modes are identical in both builds.

## Test plan
All scenarios use WIDTH=8, DIV0=4, DIV1=2, DIV2=3, DIV3=5.
- Reset pulse mid-run in mode 2 → OUT=0x00 while reset is low; OUT=0x01 one clk after release; step every 4 clks.
- Mode 1, freq 1, 16 steps → OUT 0x01,0x03,…,0xFF,0x7F,…,0x00, then 0x01 again.
- Mode 3, 37 steps → 0x01..0x80, then 0x81..0xC0, … then 0xFF, 0xFF, then 0x01. Confirm f/d boundaries.
- Mode 2 for 9 steps → wrap 0x80→0x01. With LED_BOUNCE_EN → 0x80→0x40, and 0x01 is not repeated at the lower turn.
- Change mode_sel 0→3 in the same cycle as a step → no step pulse; OUT=0x01 next clk; next step after DIV0 clks.
- pause=1 for 20 clks in mode 0 → OUT frozen and step=0; after release, the step arrives at the remaining prescaler count.

Source files
------------

// File: rtl/led_pattern_engine_if.sv
// LED pattern engine bus: switch inputs in, step pulse and LED drive out.
// master drives freq_sel/mode_sel/pause; slave returns step and OUT.
interface led_pattern_engine_if #(
  parameter int WIDTH = 8
);
  logic [1:0]       freq_sel;
  logic [1:0]       mode_sel;
  logic             pause;
  logic             step;
  logic [WIDTH-1:0] OUT;

  modport master (
    output freq_sel, mode_sel, pause,
    input  step, OUT
  );

  modport slave (
    input  freq_sel, mode_sel, pause,
    output step, OUT
  );
endinterface

// File: rtl/led_pattern_engine.sv
// LED pattern engine: prescaled step tick driving blink/fill/runner/stack
// animations. Ports: clk, reset (async active-low), bus (slave modport).
// Option LED_BOUNCE_EN: the runner bounces between the ends instead of wrapping.
module led_pattern_engine #(
  parameter int WIDTH = 8,
  parameter int DIV0  = 12_500_000,
  parameter int DIV1  = 6_250_000,
  parameter int DIV2  = 3_125_000,
  parameter int DIV3  = 1_562_500,
  parameter int CNT_W = 24
) (
  input  logic                clk,
  input  logic                reset,
  led_pattern_engine_if.slave bus
);
  localparam int KW = $clog2(WIDTH + 1);
  localparam int PW = $clog2(WIDTH);

  localparam logic [KW-1:0] KMAX = KW'(WIDTH);
  localparam logic [KW-1:0] KM1  = KW'(WIDTH - 1);
  localparam logic [PW-1:0] PMAX = PW'(WIDTH - 1);

  localparam logic [WIDTH-1:0] ALL = '1;
  localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

  localparam logic [CNT_W-1:0] LIM0 = CNT_W'(DIV0 - 1);
  localparam logic [CNT_W-1:0] LIM1 = CNT_W'(DIV1 - 1);
  localparam logic [CNT_W-1:0] LIM2 = CNT_W'(DIV2 - 1);
  localparam logic [CNT_W-1:0] LIM3 = CNT_W'(DIV3 - 1);

  logic [1:0]       mode_q, freq_q;
  logic [CNT_W-1:0] cnt_q, cnt_d, lim;
  logic             step_q;
  logic             restart, tick;

  logic             b_q, b_d;
  logic [KW-1:0]    k_q, k_d;
  logic             up_q, up_d;
  logic [PW-1:0]    p_q, p_d;
  logic [KW-1:0]    f_q, f_d;
  logic [PW-1:0]    d_q, d_d;
`ifdef LED_BOUNCE_EN
  logic             pup_q, pup_d;
`endif
  logic [WIDTH-1:0] led_q, led_d;

  always_comb begin
    unique case (freq_q)
      2'd0: lim = LIM0;
      2'd1: lim = LIM1;
      2'd2: lim = LIM2;
      2'd3: lim = LIM3;
    endcase
  end

  // A switch change restarts everything and wins over a due step.
  assign restart = (bus.mode_sel != mode_q) ||
                   (bus.freq_sel != freq_q);
  assign tick = !restart && !bus.pause && (cnt_q == lim);

  always_comb begin
    cnt_d = cnt_q;
    if (restart || tick) begin
      cnt_d = '0;
    end else if (!bus.pause) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_comb begin
    b_d  = b_q;
    k_d  = k_q;
    up_d = up_q;
    p_d  = p_q;
    f_d  = f_q;
    d_d  = d_q;
`ifdef LED_BOUNCE_EN
    pup_d = pup_q;
`endif
    if (restart) begin
      b_d  = 1'b0;
      k_d  = '0;
      up_d = 1'b1;
      p_d  = '0;
      f_d  = '0;
      d_d  = '0;
`ifdef LED_BOUNCE_EN
      pup_d = 1'b1;
`endif
    end else if (tick) begin
      unique case (mode_q)
        2'd0: b_d = ~b_q;
        2'd1: begin
          if (up_q) begin
            k_d = k_q + KW'(1);
            if (k_q == KM1) up_d = 1'b0;
          end else begin
            k_d = k_q - KW'(1);
            if (k_q == KW'(1)) up_d = 1'b1;
          end
        end
        2'd2: begin
`ifdef LED_BOUNCE_EN
          if (pup_q) begin
            p_d = p_q + PW'(1);
            if (p_q == PMAX - PW'(1)) pup_d = 1'b0;
          end else begin
            p_d = p_q - PW'(1);
            if (p_q == PW'(1)) pup_d = 1'b1;
          end
`else
          p_d = (p_q == PMAX) ? '0 : p_q + PW'(1);
`endif
        end
        2'd3: begin
          // Dot lands on top of the stack: grow stack, relaunch dot.
          if (f_q == KMAX) begin
            f_d = '0;
            d_d = '0;
          end else if (KW'(d_q) == KM1 - f_q) begin
            f_d = f_q + KW'(1);
            d_d = '0;
          end else begin
            d_d = d_q + PW'(1);
          end
        end
      endcase
    end
  end

  always_comb begin
    led_d = '0;
    if (restart) begin
      unique case (bus.mode_sel)
        2'd2, 2'd3: led_d = ONE;
        default:    led_d = '0;
      endcase
    end else begin
      unique case (mode_q)
        2'd0: led_d = {WIDTH{b_q}};
        2'd1: led_d = ~(ALL << k_q);
        2'd2: led_d = ONE << p_q;
        2'd3: led_d = ~(ALL >> f_q) |
                      ((f_q != KMAX) ? (ONE << d_q) : '0);
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      mode_q <= '0;
      freq_q <= '0;
      cnt_q  <= '0;
      step_q <= 1'b0;
      b_q    <= 1'b0;
      k_q    <= '0;
      up_q   <= 1'b1;
      p_q    <= '0;
      f_q    <= '0;
      d_q    <= '0;
`ifdef LED_BOUNCE_EN
      pup_q  <= 1'b1;
`endif
      led_q  <= '0;
    end else begin
      mode_q <= bus.mode_sel;
      freq_q <= bus.freq_sel;
      cnt_q  <= cnt_d;
      step_q <= tick;
      b_q    <= b_d;
      k_q    <= k_d;
      up_q   <= up_d;
      p_q    <= p_d;
      f_q    <= f_d;
      d_q    <= d_d;
`ifdef LED_BOUNCE_EN
      pup_q  <= pup_d;
`endif
      led_q  <= led_d;
    end
  end

  assign bus.step = step_q;
  assign bus.OUT  = led_q;
endmodule

// File: tb/tb_led_pattern_engine.sv
// Testbench for led_pattern_engine: directed step tables, corner sequences
// and random switch activity against a step-index reference model.
module tb_led_pattern_engine;
  logic clk = 1'b0;
  logic rst;
  int   n_cmp = 0;
  int   n_bad = 0;

  led_pattern_engine_if #(.WIDTH(8)) bus ();

  led_pattern_engine #(
    .WIDTH(8), .DIV0(4), .DIV1(2), .DIV2(3), .DIV3(5), .CNT_W(24)
  ) dut (
    .clk   (clk),
    .reset (rst),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  logic [7:0] stack_tab [37];
  int         m_mode, m_freq, m_phase, m_n;
  logic [7:0] m_out;
  logic       m_step;

  function automatic int divof(int f);
    case (f)
      0: return 4;
      1: return 2;
      2: return 3;
      default: return 5;
    endcase
  endfunction

  // Pattern shown after n steps from a fresh start of a mode.
  function automatic logic [7:0] pat(int mode, int n);
    int m, lv;
    case (mode)
      0: return (n % 2) ? 8'hFF : 8'h00;
      1: begin
        m  = n % 16;
        lv = (m <= 8) ? m : 16 - m;
        return 8'((1 << lv) - 1);
      end
      2: begin
`ifdef LED_BOUNCE_EN
        m  = n % 14;
        lv = (m < 8) ? m : 14 - m;
`else
        lv = n % 8;
`endif
        return 8'(1 << lv);
      end
      default: return stack_tab[n % 37];
    endcase
  endfunction

  task automatic model_reset();
    m_mode = 0; m_freq = 0; m_phase = 0; m_n = 0;
    m_out = 8'h00; m_step = 1'b0;
  endtask

  task automatic model_edge();
    bit rs, tk;
    logic [7:0] o;
    if (!rst) begin
      model_reset();
      return;
    end
    rs = (int'(bus.mode_sel) != m_mode) || (int'(bus.freq_sel) != m_freq);
    o  = rs ? pat(int'(bus.mode_sel), 0) : pat(m_mode, m_n);
    tk = !rs && !bus.pause && (m_phase == divof(m_freq) - 1);
    if (rs) begin
      m_phase = 0; m_n = 0;
    end else if (!bus.pause) begin
      if (tk) begin
        m_phase = 0; m_n++;
      end else begin
        m_phase++;
      end
    end
    m_step = tk;
    m_out  = o;
    m_mode = int'(bus.mode_sel);
    m_freq = int'(bus.freq_sel);
  endtask

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    model_edge();
    #1;
    chk("out", 32'(bus.OUT), 32'(m_out));
    chk("step", 32'(bus.step), 32'(m_step));
  endtask

  task automatic hard_start(logic [1:0] md, logic [1:0] fq);
    rst = 1'b0;
    bus.pause = 1'b0;
    bus.mode_sel = md;
    bus.freq_sel = fq;
    #1;
    model_reset();
    cyc();
    rst = 1'b1;
  endtask

  task automatic wait_step(output int n);
    n = 0;
    do begin
      cyc();
      n++;
    end while (!bus.step && n < 100);
  endtask

  typedef struct {
    logic [1:0] mode;
    logic [1:0] freq;
    int         nsteps;
    logic [7:0] exp;
  } vec_t;

`ifdef LED_BOUNCE_EN
  localparam logic [7:0] E2_8 = 8'h40, E2_13 = 8'h02, E2_14 = 8'h01;
`else
  localparam logic [7:0] E2_8 = 8'h01, E2_13 = 8'h20, E2_14 = 8'h40;
`endif

  vec_t vt [20] = '{
    '{2'd0, 2'd0, 1,  8'hFF}, '{2'd0, 2'd0, 2,  8'h00},
    '{2'd1, 2'd1, 1,  8'h01}, '{2'd1, 2'd1, 8,  8'hFF},
    '{2'd1, 2'd1, 9,  8'h7F}, '{2'd1, 2'd1, 16, 8'h00},
    '{2'd1, 2'd1, 17, 8'h01}, '{2'd3, 2'd2, 7,  8'h80},
    '{2'd3, 2'd2, 8,  8'h81}, '{2'd3, 2'd2, 14, 8'hC0},
    '{2'd3, 2'd2, 15, 8'hC1}, '{2'd3, 2'd2, 35, 8'hFF},
    '{2'd3, 2'd2, 36, 8'hFF}, '{2'd3, 2'd2, 37, 8'h01},
    '{2'd2, 2'd3, 7,  8'h80}, '{2'd2, 2'd3, 8,  E2_8},
    '{2'd2, 2'd3, 13, E2_13}, '{2'd2, 2'd3, 14, E2_14},
    '{2'd2, 2'd1, 3,  8'h08}, '{2'd3, 2'd3, 36, 8'hFF}
  };

  initial begin
    int idx, seen, g, n, ph;
    idx = 0;
    for (int f = 0; f < 8; f++) begin
      for (int d = 0; d <= 7 - f; d++) begin
        stack_tab[idx] = 8'((((1 << f) - 1) << (8 - f)) | (1 << d));
        idx++;
      end
    end
    stack_tab[36] = 8'hFF;

    rst = 1'b0;
    bus.pause = 1'b0;
    bus.mode_sel = 2'd0;
    bus.freq_sel = 2'd0;
    model_reset();
    repeat (2) cyc();
    chk("rst_out", 32'(bus.OUT), 32'h0);
    chk("rst_step", 32'(bus.step), 32'h0);
    rst = 1'b1;

    foreach (vt[i]) begin
      hard_start(vt[i].mode, vt[i].freq);
      seen = 0;
      g = 0;
      while (seen < vt[i].nsteps && g < 1000) begin
        cyc();
        g++;
        if (bus.step) seen++;
      end
      chk("vec_steps", 32'(seen), 32'(vt[i].nsteps));
      cyc();
      chk("vec_out", 32'(bus.OUT), 32'(vt[i].exp));
    end

    // Reset mid-run in the runner mode.
    hard_start(2'd2, 2'd0);
    repeat (13) cyc();
    rst = 1'b0;
    #1;
    model_reset();
    chk("async_rst_out", 32'(bus.OUT), 32'h0);
    cyc();
    chk("held_rst_out", 32'(bus.OUT), 32'h0);
    rst = 1'b1;
    cyc();
    chk("rel_out", 32'(bus.OUT), 32'h01);
    wait_step(n);
    wait_step(n);
    chk("step_period", 32'(n), 32'd4);

    // Switch mode on the very cycle a step is due.
    hard_start(2'd0, 2'd0);
    repeat (3) cyc();
    g = 0;
    while (m_phase != 3 && g < 10) begin
      cyc();
      g++;
    end
    chk("phase_found", 32'(m_phase), 32'd3);
    bus.mode_sel = 2'd3;
    cyc();
    chk("coinc_step", 32'(bus.step), 32'h0);
    chk("coinc_out", 32'(bus.OUT), 32'h01);
    wait_step(n);
    chk("coinc_next", 32'(n), 32'd4);

    // Pause freezes animation and prescaler.
    hard_start(2'd0, 2'd0);
    repeat (6) cyc();
    ph = m_phase;
    bus.pause = 1'b1;
    repeat (20) begin
      cyc();
      chk("pause_step", 32'(bus.step), 32'h0);
      chk("pause_out", 32'(bus.OUT), 32'hFF);
    end
    bus.pause = 1'b0;
    wait_step(n);
    chk("pause_resume", 32'(n), 32'(4 - ph));

    // Random switch, pause and reset activity.
    hard_start(2'd1, 2'd1);
    for (int i = 0; i < 1500; i++) begin
      int r;
      r = $urandom_range(0, 199);
      rst = 1'b1;
      if (r < 4) bus.mode_sel = 2'($urandom_range(0, 3));
      else if (r < 7) bus.freq_sel = 2'($urandom_range(0, 3));
      else if (r < 12) bus.pause = ~bus.pause;
      else if (r == 199) rst = 1'b0;
      cyc();
    end
    rst = 1'b1;
    cyc();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
